// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle LEGv8 control unit (Moore FSM).
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It also
// provides memory wait states, a wait-timeout fault and illegal-opcode
// trapping. All outputs are derived from state, latched class, wait counter
// and the Zero/MemReady inputs, so an asynchronous Reset drops every enable
// at once.
//
// Optional feature macro: CTRL_CBNZ_EN (adds CBNZ 10110101xxx).
//
// Parameters:
//   OPCODE_W    opcode width; only the upper 11 bits are decoded
//   MEM_TIMEOUT max consecutive not-ready cycles in FETCH/MEM; 0 disables
// Ports:
//   CLK, Reset                    clock (rising), async active-high reset
//   Opcode                        IR opcode field, sampled only in DECODE
//   Zero                          ALU zero flag (conditional branches)
//   MemReady                      memory completes access this cycle
//   Reg2Loc, ALUSrc, MemToReg,
//   RegWrite, MemRead, MemWrite   datapath controls
//   IorD                          memory address select (0 PC, 1 ALU)
//   IRWrite, PCWrite, PCSrc       IR load, PC load, PC source (1 = branch)
//   ALUOp                         00 add, 01 pass/zero-test, 10 R-type
//   InstrDone                     pulse in an instruction's final state
//   Fault                         high while in FAULT
module multicycle_control #(
  parameter int unsigned OPCODE_W    = 11,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                Reg2Loc,
  output logic                ALUSrc,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic [1:0]          ALUOp,
  output logic                InstrDone,
  output logic                Fault
);

  localparam int unsigned CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned CNT_LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_ILLEGAL, C_LDUR, C_STUR, C_RTYPE, C_CBZ, C_CBNZ, C_B
  } class_t;

  state_t           state, next_state;
  class_t           cls, dec_class;
  logic [CNT_W-1:0] wait_cnt;
  logic [10:0]      op_hi;
  logic             wait_timeout;

  assign op_hi = Opcode[OPCODE_W-1 -: 11];

  // Instruction class from the live opcode (used only in DECODE)
  always_comb begin
    dec_class = C_ILLEGAL;
    casez (op_hi)
      11'b11111000010: dec_class = C_LDUR;
      11'b11111000000: dec_class = C_STUR;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_class = C_RTYPE;
      11'b10110100???: dec_class = C_CBZ;
`ifdef CTRL_CBNZ_EN
      11'b10110101???: dec_class = C_CBNZ;
`endif
      11'b000101?????: dec_class = C_B;
      default:         dec_class = C_ILLEGAL;
    endcase
  end

  // Not ready on the last tolerated wait cycle forces FAULT
  assign wait_timeout = TIMEOUT_EN && !MemReady && (wait_cnt == CNT_W'(CNT_LIMIT));

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Class latch and wait counter
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cls      <= C_ILLEGAL;
      wait_cnt <= '0;
    end else begin
      if (state == S_DECODE) cls <= dec_class;
      if ((next_state != state) && ((next_state == S_FETCH) || (next_state == S_MEM)))
        wait_cnt <= '0;
      else if (TIMEOUT_EN && !MemReady && ((state == S_FETCH) || (state == S_MEM)))
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next state and Moore outputs (plus MemReady/Zero qualified terms)
  always_comb begin
    next_state = state;
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    ALUOp      = 2'b00;
    InstrDone  = 1'b0;
    Fault      = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end else if (wait_timeout) begin
          next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        Reg2Loc    = (dec_class == C_STUR) || (dec_class == C_CBZ) || (dec_class == C_CBNZ);
        next_state = (dec_class == C_ILLEGAL) ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        Reg2Loc = (cls == C_STUR) || (cls == C_CBZ) || (cls == C_CBNZ);
        case (cls)
          C_LDUR, C_STUR: begin
            ALUSrc     = 1'b1;
            next_state = S_MEM;
          end
          C_RTYPE: begin
            ALUOp      = 2'b10;
            next_state = S_WB;
          end
          C_CBZ, C_CBNZ: begin
            ALUOp      = 2'b01;
            PCSrc      = 1'b1;
            PCWrite    = (cls == C_CBZ) ? Zero : ~Zero;
            InstrDone  = 1'b1;
            next_state = S_FETCH;
          end
          C_B: begin
            PCSrc      = 1'b1;
            PCWrite    = 1'b1;
            InstrDone  = 1'b1;
            next_state = S_FETCH;
          end
          default: next_state = S_FAULT;
        endcase
      end
      S_MEM: begin
        IorD     = 1'b1;
        ALUSrc   = 1'b1;
        Reg2Loc  = (cls == C_STUR);
        MemRead  = (cls == C_LDUR);
        MemWrite = (cls == C_STUR);
        if (MemReady) begin
          if (cls == C_LDUR) begin
            next_state = S_WB;
          end else begin
            InstrDone  = 1'b1;
            next_state = S_FETCH;
          end
        end else if (wait_timeout) begin
          next_state = S_FAULT;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = (cls == C_LDUR);
        InstrDone  = 1'b1;
        next_state = S_FETCH;
      end
      S_FAULT: Fault = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-cycle vector table plus hand-written
// timeout-latch and asynchronous-reset sequences. Built with MEM_TIMEOUT=4.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] Opcode = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
  logic        IorD, IRWrite, PCWrite, PCSrc, InstrDone, Fault;
  logic [1:0]  ALUOp;
  logic [13:0] outs;

  multicycle_control #(.OPCODE_W(11), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUOp(ALUOp), .InstrDone(InstrDone),
    .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  assign outs = {Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, IorD,
                 IRWrite, PCWrite, PCSrc, ALUOp, InstrDone, Fault};

  localparam logic [13:0] NONE = 14'h0000;
  localparam logic [13:0] R2L  = 14'h2000;
  localparam logic [13:0] ALS  = 14'h1000;
  localparam logic [13:0] M2R  = 14'h0800;
  localparam logic [13:0] RW   = 14'h0400;
  localparam logic [13:0] MR   = 14'h0200;
  localparam logic [13:0] MW   = 14'h0100;
  localparam logic [13:0] IORD = 14'h0080;
  localparam logic [13:0] IRW  = 14'h0040;
  localparam logic [13:0] PCW  = 14'h0020;
  localparam logic [13:0] PCS  = 14'h0010;
  localparam logic [13:0] AOPR = 14'h0008;
  localparam logic [13:0] AOPZ = 14'h0004;
  localparam logic [13:0] DONE = 14'h0002;
  localparam logic [13:0] FLT  = 14'h0001;
  localparam logic [13:0] FOK  = MR | IRW | PCW;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBZ7 = 11'b10110100111;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_B    = 11'b00010111111;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  typedef struct {
    logic        rst;
    logic [10:0] op;
    logic        z;
    logic        mr;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  task automatic add(input logic rst, input logic [10:0] op, input logic z,
                     input logic mr, input logic [13:0] exp);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.mr = mr; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [13:0] want);
    total++;
    if (outs !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, outs, want);
    end
  endtask

  // One clock cycle: drive at negedge, compare just before the next posedge
  task automatic cyc(input logic rst, input logic [10:0] op, input logic z,
                     input logic mr, input logic [13:0] want, input string name);
    @(negedge CLK);
    Reset = rst; Opcode = op; Zero = z; MemReady = mr;
    #4;
    check(name, want);
  endtask

  initial begin
    // Reset 3 cycles, then ADD with zero wait
    repeat (3) add(1, OP_ADD, 0, 1, NONE);
    add(0, OP_ADD, 0, 1, NONE);                 // IDLE
    add(0, OP_ADD, 0, 1, FOK);                  // FETCH
    add(0, OP_ADD, 0, 1, NONE);                 // DECODE
    add(0, OP_ADD, 0, 1, AOPR);                 // EXEC
    add(0, OP_ADD, 0, 1, RW | DONE);            // WB
    // LDUR: 2 waits in FETCH, 3 in MEM, 10 cycles total
    add(0, OP_LDUR, 0, 0, MR);
    add(0, OP_LDUR, 0, 0, MR);
    add(0, OP_LDUR, 0, 1, FOK);
    add(0, OP_LDUR, 0, 1, NONE);
    add(0, OP_LDUR, 0, 1, ALS);
    repeat (3) add(0, OP_LDUR, 0, 0, IORD | ALS | MR);
    add(0, OP_LDUR, 0, 1, IORD | ALS | MR);
    add(0, OP_LDUR, 0, 1, RW | M2R | DONE);
    // CBZ taken
    add(0, OP_CBZ, 1, 1, FOK);
    add(0, OP_CBZ, 1, 1, R2L);
    add(0, OP_CBZ, 1, 1, R2L | AOPZ | PCS | PCW | DONE);
    // CBZ not taken (low opcode bits are don't-care)
    add(0, OP_CBZ7, 0, 1, FOK);
    add(0, OP_CBZ7, 0, 1, R2L);
    add(0, OP_CBZ7, 0, 1, R2L | AOPZ | PCS | DONE);
    // B
    add(0, OP_B, 0, 1, FOK);
    add(0, OP_B, 0, 1, NONE);
    add(0, OP_B, 0, 1, PCS | PCW | DONE);
    // STUR with Opcode switched to ADD after DECODE
    add(0, OP_STUR, 0, 1, FOK);
    add(0, OP_STUR, 0, 1, R2L);
    add(0, OP_ADD, 0, 1, R2L | ALS);
    add(0, OP_ADD, 0, 1, IORD | ALS | R2L | MW | DONE);
    // MemReady arrives on the 4th FETCH cycle: advance, no fault
    repeat (3) add(0, OP_SUB, 0, 0, MR);
    add(0, OP_SUB, 0, 1, FOK);
    add(0, OP_SUB, 0, 1, NONE);
    add(0, OP_SUB, 0, 1, AOPR);
    add(0, OP_SUB, 0, 1, RW | DONE);
    // ORR
    add(0, OP_ORR, 0, 1, FOK);
    add(0, OP_ORR, 0, 1, NONE);
    add(0, OP_ORR, 0, 1, AOPR);
    add(0, OP_ORR, 0, 1, RW | DONE);
    // Illegal opcode traps and stays in FAULT
    add(0, OP_ILL, 0, 1, FOK);
    add(0, OP_ILL, 0, 1, NONE);
    add(0, OP_ADD, 1, 1, FLT);
    add(0, OP_ADD, 0, 0, FLT);
    // CBNZ
    add(1, OP_CBNZ, 0, 1, NONE);
    add(0, OP_CBNZ, 0, 1, NONE);
    add(0, OP_CBNZ, 0, 1, FOK);
`ifdef CTRL_CBNZ_EN
    add(0, OP_CBNZ, 0, 1, R2L);
    add(0, OP_CBNZ, 0, 1, R2L | AOPZ | PCS | PCW | DONE);
    add(0, OP_CBNZ, 1, 1, FOK);
    add(0, OP_CBNZ, 1, 1, R2L);
    add(0, OP_CBNZ, 1, 1, R2L | AOPZ | PCS | DONE);
`else
    add(0, OP_CBNZ, 0, 1, NONE);
    add(0, OP_CBNZ, 0, 1, FLT);
`endif

    #1;
    check("reset_state", NONE);
    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].exp,
          $sformatf("vec%0d", i));

    // FETCH timeout: 4 not-ready cycles tolerated, then FAULT latched
    cyc(1, OP_ADD, 0, 0, NONE, "to_rst");
    cyc(0, OP_ADD, 0, 0, NONE, "to_idle");
    for (int i = 0; i < 4; i++) cyc(0, OP_ADD, 0, 0, MR, $sformatf("to_wait%0d", i));
    for (int i = 0; i < 6; i++)
      cyc(0, 11'($urandom), 1'($urandom), 1'($urandom), FLT, $sformatf("fault_hold%0d", i));

    // Asynchronous reset in the middle of a STUR memory wait
    cyc(1, OP_STUR, 0, 1, NONE, "ar_rst");
    cyc(0, OP_STUR, 0, 1, NONE, "ar_idle");
    cyc(0, OP_STUR, 0, 1, FOK, "ar_fetch");
    cyc(0, OP_STUR, 0, 1, R2L, "ar_decode");
    cyc(0, OP_STUR, 0, 1, R2L | ALS, "ar_exec");
    @(negedge CLK);
    MemReady = 1'b0;
    #1;
    check("ar_mem", IORD | ALS | R2L | MW);
    #1;
    Reset = 1'b1;
    #1;
    check("ar_async", NONE);
    cyc(0, OP_ADD, 0, 1, NONE, "ar_post_idle");
    cyc(0, OP_ADD, 0, 1, FOK, "ar_refetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle LEGv8 control unit: a Moore state machine that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB steps, replacing single-cycle combinational decode. It sits between the instruction register (Opcode), the ALU Zero flag and a shared instruction/data memory with a ready handshake, and drives the datapath muxes and write enables. It adds memory wait states, a wait-timeout fault, illegal-opcode trapping and fully defined (never x) outputs.

## Interface
- OPCODE_W, 11, opcode width; decode compares the upper 11 bits, and extra low bits are ignored.
- MEM_TIMEOUT, 15, max consecutive not-ready cycles in FETCH/MEM before FAULT; 0 disables timeout.
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Opcode  input  OPCODE_W  instruction opcode field from the IR; sampled only in DECODE.
- Zero  input  1  ALU zero flag, used in EXEC of conditional branches.
- MemReady  input  1  memory completes current access this cycle.
- Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite  output  1 each  same meaning as the single-cycle control.
- IorD  output  1  memory address select: 0 = PC, 1 = ALU result.
- IRWrite  output  1  load instruction register.
- PCWrite  output  1  load PC.
- PCSrc  output  1  PC source: 0 = PC+4, 1 = branch target.
- ALUOp  output  2  00 add, 01 pass/zero-test, 10 R-type function.
- InstrDone  output  1  one-cycle pulse in an instruction's final state.
- Fault  output  1  high while in FAULT.

## Operation
- Classes decoded from the upper 11 opcode bits: LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, CBZ 10110100xxx, B 000101xxxxx; anything else is ILLEGAL.
- Class is latched in DECODE into a class register, and Opcode is ignored afterwards.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT. Outputs not listed for a state are 0.
- IDLE: all outputs 0; next FETCH.
- FETCH: IorD=0, MemRead=1. On MemReady: IRWrite=1, PCWrite=1, PCSrc=0, and next state is DECODE. Otherwise stay.
- DECODE: Reg2Loc=1 for STUR/CBZ, else 0. ILLEGAL -> FAULT, else -> EXEC.
- EXEC: Reg2Loc held as in DECODE.
  - LDUR/STUR: ALUSrc=1, ALUOp=00 -> MEM.
  - R-type: ALUOp=10 -> WB.
  - CBZ: ALUOp=01, PCSrc=1, PCWrite=Zero, InstrDone=1 -> FETCH.
  - B: PCSrc=1, PCWrite=1, InstrDone=1 -> FETCH.
- MEM: IorD=1, ALUSrc=1, ALUOp=00, Reg2Loc=1 for STUR. LDUR asserts MemRead; STUR asserts MemWrite. Wait for MemReady. On MemReady, LDUR -> WB, and STUR asserts InstrDone -> FETCH.
- WB: RegWrite=1, MemToReg=1 for LDUR, else 0; InstrDone=1 -> FETCH.
- FAULT: Fault=1, all other outputs 0; exit only via Reset.
- Wait counter (width $clog2(MEM_TIMEOUT+1), minimum 1):
  - Cleared on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle with MemReady=0.
  - If MemReady=0 while count==MEM_TIMEOUT-1, the next state is FAULT: exactly MEM_TIMEOUT not-ready cycles are tolerated.
  - MemReady on the same cycle as the limit wins (normal advance).

## Timing
- Reset asserted: state=IDLE, class=ILLEGAL, counter=0, and every output 0 immediately (asynchronous). First FETCH is one cycle after Reset deasserts.
- Outputs are a pure function of state, class, counter and Zero/MemReady. They change only after CLK, except the combinational MemReady/Zero terms listed above.
- Latency with zero wait (MemReady high on first cycle), counted in cycles from FETCH entry: B/CBZ 3, R-type 4, STUR 4, LDUR 5. Each not-ready cycle in FETCH or MEM adds 1.
- Reset mid-instruction aborts immediately with no partial writes, since all enables drop asynchronously.

## Configuration
- CTRL_CBNZ_EN:
  - Defined: adds CBNZ 10110101xxx. It behaves as CBZ (Reg2Loc=1, ALUOp=01, 3 cycles) but with PCWrite=~Zero in EXEC.
  - Undefined: 10110101xxx decodes as ILLEGAL -> FAULT.

## Test plan
- Reset high for 3 cycles, then release with MemReady=1, Opcode=ADD: all outputs 0 during Reset. Then IDLE, FETCH (IRWrite=1, PCWrite=1), DECODE, EXEC (ALUOp=10), WB (RegWrite=1, InstrDone=1).
- LDUR with MemReady low 2 cycles in FETCH and 3 in MEM: total 10 cycles; MemRead held throughout waits; WB has MemToReg=1, RegWrite=1.
- CBZ with Zero=1, then Zero=0: EXEC PCWrite=1, PCSrc=1 versus PCWrite=0. Both take 3 cycles with InstrDone pulsed once.
- MEM_TIMEOUT=4, MemReady stuck low in FETCH: FAULT entered after 4 wait cycles, Fault=1, stays latched until Reset. MemReady rising on the 4th cycle instead advances to DECODE.
- Opcode=11111111111: DECODE -> FAULT, no RegWrite/MemWrite/PCWrite after fetch. CBNZ 10110101000 faults without CTRL_CBNZ_EN and branches on Zero=0 with it.
- Change Opcode from STUR to ADD during EXEC: block still completes STUR (MemWrite=1 in MEM, no WB).
